// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: applies RPC chained rounds per clock over a 64-round block,
// with optional feed-forward of the chaining value into the registered digest.
module sha256_round_engine #(
  parameter int unsigned RPC      = 1,
  parameter bit          FEED_FWD = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [255:0]       hash_in,
  input  logic [32*RPC-1:0]  w_in,
  input  logic               w_valid,
  output logic [5:0]         round_idx,
  output logic               busy,
  output logic               done,
  output logic [255:0]       digest
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sha256_round_engine: RPC must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;
  // Word 0 is a (H0), word 7 is h (H7), matching the hash_in bit layout.
  typedef logic [0:7][31:0] words_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic words_t sha_round(input words_t v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] s0, s1, ch, maj, t1, t2;
    words_t      r;
    s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
    ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
    t1  = v[7] + s1 + ch + k + w;
    s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
    maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t2  = s0 + maj;
    r   = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
    return r;
  endfunction

  state_t      state_q, state_d;
  words_t      var_q, var_d, hreg_q, hreg_d, rounds_out, digest_q, digest_d;
  logic [5:0]  round_idx_q, round_idx_d;
  logic        busy_q, busy_d, done_q, done_d;

  always_comb begin
    rounds_out = var_q;
    for (int unsigned j = 0; j < RPC; j++) begin
      rounds_out = sha_round(rounds_out, K_ROM[round_idx_q + 6'(j)], w_in[32*j +: 32]);
    end
  end

  always_comb begin
    state_d     = state_q;
    var_d       = var_q;
    hreg_d      = hreg_q;
    round_idx_d = round_idx_q;
    digest_d    = digest_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          var_d       = hash_in;
          hreg_d      = hash_in;
          round_idx_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (w_valid) begin
          var_d       = rounds_out;
          round_idx_d = round_idx_q + 6'(RPC);
          if (round_idx_q == 6'(64 - RPC)) state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = IDLE;
        if (!abort) begin
          for (int unsigned i = 0; i < 8; i++) begin
            digest_d[i] = FEED_FWD ? hreg_q[i] + var_q[i] : var_q[i];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      var_q       <= '0;
      hreg_q      <= '0;
      round_idx_q <= '0;
      digest_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      var_q       <= var_d;
      hreg_q      <= hreg_d;
      round_idx_q <= round_idx_d;
      digest_q    <= digest_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign digest    = digest_q;

endmodule
